// File: rtl/fetch_queue.sv
// fetch_queue: per-instruction fetch queue between IF1 and decode.
//   Accepts one 2-slot fetch packet per cycle, compacts the valid slots
//   (in slot order) into a circular queue, and presents head / head+1
//   first-word-fall-through for dual-issue decode. Decode pops 0..2 per cycle.
//   PC, badv and metadata are kept per instruction, so a packet may be split
//   across two pops.
// Ports:
//   clk, rstn            clock, synchronous active-low reset
//   flush                discard all contents (beats write and pop)
//   in_valid/in_mask     packet present / per-slot valid ([0]=slot0)
//   in_inst0/1, in_pc    slot instructions; slot1 PC is in_pc+4
//   in_badv, in_meta     per-packet data copied to every written slot
//   in_ready             packet accepted when in_valid=1 (>=2 free entries)
//   nearly_full, count   free < NF_THRESH / occupancy 0..DEPTH
//   out_valid[1:0]       head / head+1 present
//   out_*0, out_*1       head / head+1 fields (defaults when not present)
//   pop_cnt              instructions consumed this cycle (0..2)
`ifndef INST_NOP
`define INST_NOP 32'h0340_0000
`endif
`ifndef PC_RESET
`define PC_RESET 32'h1C00_0000
`endif

module fetch_queue #(
  parameter int DEPTH     = 16,
  parameter int LOG_DEPTH = 4,
  parameter int META_W    = 45,
  parameter int NF_THRESH = 4
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 flush,
  input  logic                 in_valid,
  input  logic [1:0]           in_mask,
  input  logic [31:0]          in_inst0,
  input  logic [31:0]          in_inst1,
  input  logic [31:0]          in_pc,
  input  logic [31:0]          in_badv,
  input  logic [META_W-1:0]    in_meta,
  output logic                 in_ready,
  output logic                 nearly_full,
  output logic [LOG_DEPTH:0]   count,
  output logic [1:0]           out_valid,
  output logic [31:0]          out_inst0,
  output logic [31:0]          out_inst1,
  output logic [31:0]          out_pc0,
  output logic [31:0]          out_pc1,
  output logic [31:0]          out_badv0,
  output logic [31:0]          out_badv1,
  output logic [META_W-1:0]    out_meta0,
  output logic [META_W-1:0]    out_meta1,
  input  logic [1:0]           pop_cnt
);

  localparam logic [LOG_DEPTH:0] DEPTH_C = (LOG_DEPTH+1)'(DEPTH);
  localparam logic [LOG_DEPTH:0] NF_C    = (LOG_DEPTH+1)'(NF_THRESH);

  logic [31:0]          inst_q [DEPTH];
  logic [31:0]          pc_q   [DEPTH];
  logic [31:0]          badv_q [DEPTH];
  logic [META_W-1:0]    meta_q [DEPTH];

  logic [LOG_DEPTH-1:0] rd_ptr, wr_ptr, wr_ptr1;
  logic [LOG_DEPTH:0]   count_q, free, count_nxt;
  logic [1:0]           n_wr, wr_n, pop_req, eff_pop;
  logic                 wr_en;
  logic [31:0]          first_inst, first_pc;

  // Status is derived from registered count only: no path from pop_cnt.
  assign free        = DEPTH_C - count_q;
  assign in_ready    = free >= (LOG_DEPTH+1)'(2);
  assign nearly_full = free < NF_C;
  assign count       = count_q;

  assign wr_en   = in_valid && in_ready;
  assign n_wr    = {1'b0, in_mask[0]} + {1'b0, in_mask[1]};
  assign wr_n    = wr_en ? n_wr : 2'd0;
  assign wr_ptr1 = wr_ptr + 1'b1;

  // Over-pop is clamped to occupancy; pop_cnt=3 is treated as 2 first.
  assign pop_req = (pop_cnt == 2'd3) ? 2'd2 : pop_cnt;
  assign eff_pop = ({{(LOG_DEPTH-1){1'b0}}, pop_req} > count_q) ? count_q[1:0] : pop_req;

  assign count_nxt = count_q + {{(LOG_DEPTH-1){1'b0}}, wr_n}
                             - {{(LOG_DEPTH-1){1'b0}}, eff_pop};

  // Compaction: the lowest valid slot always lands at wr_ptr.
  assign first_inst = in_mask[0] ? in_inst0 : in_inst1;
  assign first_pc   = in_mask[0] ? in_pc    : in_pc + 32'd4;

  always_ff @(posedge clk) begin
    if (!rstn || flush) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
    end else begin
      assert ({{(LOG_DEPTH-1){1'b0}}, pop_cnt} <= count_q)
        else $warning("fetch_queue: pop_cnt %0d exceeds count %0d", pop_cnt, count_q);
      rd_ptr  <= rd_ptr + {{(LOG_DEPTH-2){1'b0}}, eff_pop};
      wr_ptr  <= wr_ptr + {{(LOG_DEPTH-2){1'b0}}, wr_n};
      count_q <= count_nxt;
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (rstn && !flush && wr_en) begin
      if (n_wr != 2'd0) begin
        inst_q[wr_ptr] <= first_inst;
        pc_q[wr_ptr]   <= first_pc;
        badv_q[wr_ptr] <= in_badv;
        meta_q[wr_ptr] <= in_meta;
      end
      if (n_wr == 2'd2) begin
        inst_q[wr_ptr1] <= in_inst1;
        pc_q[wr_ptr1]   <= in_pc + 32'd4;
        badv_q[wr_ptr1] <= in_badv;
        meta_q[wr_ptr1] <= in_meta;
      end
    end
  end

  logic [1:0][31:0]       lane_inst, lane_pc, lane_badv;
  logic [1:0][META_W-1:0] lane_meta;

  for (genvar k = 0; k < 2; k++) begin : g_lane
    logic [LOG_DEPTH-1:0] idx;
    assign idx          = rd_ptr + LOG_DEPTH'(k);
    assign out_valid[k] = count_q > (LOG_DEPTH+1)'(k);
    assign lane_inst[k] = out_valid[k] ? inst_q[idx] : `INST_NOP;
    assign lane_pc[k]   = out_valid[k] ? pc_q[idx]   : `PC_RESET;
    assign lane_badv[k] = out_valid[k] ? badv_q[idx] : `PC_RESET;
    assign lane_meta[k] = out_valid[k] ? meta_q[idx] : '0;
  end

  assign out_inst0 = lane_inst[0];
  assign out_inst1 = lane_inst[1];
  assign out_pc0   = lane_pc[0];
  assign out_pc1   = lane_pc[1];
  assign out_badv0 = lane_badv[0];
  assign out_badv1 = lane_badv[1];
  assign out_meta0 = lane_meta[0];
  assign out_meta1 = lane_meta[1];

endmodule

// File: tb/tb_fetch_queue.sv
// Testbench for fetch_queue: constant vector table for the directed cases
// plus a queue-based scoreboard that checks every visible output each cycle.
`ifndef INST_NOP
`define INST_NOP 32'h0340_0000
`endif
`ifndef PC_RESET
`define PC_RESET 32'h1C00_0000
`endif

module tb_fetch_queue;
  localparam int DEPTH = 16, LOG_DEPTH = 4, META_W = 45, NF = 4;

  logic clk = 0, rstn = 0, flush = 0, in_valid = 0;
  logic [1:0] in_mask = 0, pop_cnt = 0;
  logic [31:0] in_inst0 = 0, in_inst1 = 0, in_pc = 0, in_badv = 0;
  logic [META_W-1:0] in_meta = 0;
  logic in_ready, nearly_full;
  logic [LOG_DEPTH:0] count;
  logic [1:0] out_valid;
  logic [31:0] out_inst0, out_inst1, out_pc0, out_pc1, out_badv0, out_badv1;
  logic [META_W-1:0] out_meta0, out_meta1;

  fetch_queue #(.DEPTH(DEPTH), .LOG_DEPTH(LOG_DEPTH), .META_W(META_W), .NF_THRESH(NF)) dut (
    .clk(clk), .rstn(rstn), .flush(flush), .in_valid(in_valid), .in_mask(in_mask),
    .in_inst0(in_inst0), .in_inst1(in_inst1), .in_pc(in_pc), .in_badv(in_badv),
    .in_meta(in_meta), .in_ready(in_ready), .nearly_full(nearly_full), .count(count),
    .out_valid(out_valid), .out_inst0(out_inst0), .out_inst1(out_inst1),
    .out_pc0(out_pc0), .out_pc1(out_pc1), .out_badv0(out_badv0), .out_badv1(out_badv1),
    .out_meta0(out_meta0), .out_meta1(out_meta1), .pop_cnt(pop_cnt));

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] inst, pc, badv;
    logic [META_W-1:0] meta;
  } ent_t;
  ent_t q[$];

  int errors = 0, checks = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Compare every output against the scoreboard state.
  task automatic chk_outputs();
    int n;
    ent_t e0, e1, d;
    n = q.size();
    d = '{`INST_NOP, `PC_RESET, `PC_RESET, '0};
    e0 = (n >= 1) ? q[0] : d;
    e1 = (n >= 2) ? q[1] : d;
    check("count", 64'(count), 64'(n));
    check("in_ready", 64'(in_ready), 64'((DEPTH - n) >= 2));
    check("nearly_full", 64'(nearly_full), 64'((DEPTH - n) < NF));
    check("out_valid", 64'(out_valid), {62'd0, n >= 2, n >= 1});
    check("out_inst0", 64'(out_inst0), 64'(e0.inst));
    check("out_pc0", 64'(out_pc0), 64'(e0.pc));
    check("out_badv0", 64'(out_badv0), 64'(e0.badv));
    check("out_meta0", 64'(out_meta0), 64'(e0.meta));
    check("out_inst1", 64'(out_inst1), 64'(e1.inst));
    check("out_pc1", 64'(out_pc1), 64'(e1.pc));
    check("out_badv1", 64'(out_badv1), 64'(e1.badv));
    check("out_meta1", 64'(out_meta1), 64'(e1.meta));
  endtask

  // One clock: check current outputs, drive inputs, update model, advance.
  task automatic step(input logic fl, input logic v, input logic [1:0] m,
                      input logic [31:0] i0, input logic [31:0] i1,
                      input logic [31:0] pc, input logic [1:0] pop);
    int eff;
    bit rdy;
    logic [31:0] bv;
    logic [META_W-1:0] mt;
    chk_outputs();
    bv = pc ^ 32'h5A5A_0000;
    mt = {13'($urandom), 32'($urandom)};
    flush = fl; in_valid = v; in_mask = m; in_inst0 = i0; in_inst1 = i1;
    in_pc = pc; in_badv = bv; in_meta = mt; pop_cnt = pop;
    if (fl) q.delete();
    else begin
      rdy = (DEPTH - q.size()) >= 2;
      eff = (int'(pop) > q.size()) ? q.size() : int'(pop);
      for (int k = 0; k < eff; k++) void'(q.pop_front());
      if (v && rdy) begin
        if (m[0]) q.push_back('{i0, pc, bv, mt});
        if (m[1]) q.push_back('{i1, pc + 32'd4, bv, mt});
      end
    end
    @(posedge clk); #1;
    flush = 0; in_valid = 0; in_mask = 0; pop_cnt = 0;
  endtask

  task automatic do_reset();
    rstn = 0; in_valid = 1; in_mask = 2'b11; in_inst0 = 32'hDEAD_0000; pop_cnt = 0;
    repeat (2) @(posedge clk);
    #1;
    rstn = 1; in_valid = 0; in_mask = 0;
    q.delete();
    check("rst_count", 64'(count), 0);
    check("rst_out_valid", 64'(out_valid), 0);
    check("rst_in_ready", 64'(in_ready), 1);
    check("rst_nearly_full", 64'(nearly_full), 0);
    check("rst_inst0", 64'(out_inst0), 64'(`INST_NOP));
    check("rst_pc0", 64'(out_pc0), 64'(`PC_RESET));
  endtask

  typedef struct {
    logic fl, v;
    logic [1:0] m;
    logic [31:0] i0, i1, pc;
    logic [1:0] pop;
    int cnt;
    logic [1:0] vld;
    logic [31:0] hi, hpc;
  } vec_t;
  vec_t tbl[13];

  initial begin
    tbl[0]  = '{0, 1, 2'b10, 32'h0, 32'h0280_0421, 32'h1C00_0100, 2'd0, 1, 2'b01, 32'h0280_0421, 32'h1C00_0104};
    tbl[1]  = '{0, 1, 2'b11, 32'hA000_0001, 32'hA000_0002, 32'h1C00_0200, 2'd0, 3, 2'b11, 32'h0280_0421, 32'h1C00_0104};
    tbl[2]  = '{0, 1, 2'b01, 32'hB000_0001, 32'h0, 32'h1C00_0300, 2'd1, 3, 2'b11, 32'hA000_0001, 32'h1C00_0200};
    tbl[3]  = '{0, 1, 2'b11, 32'hC000_0001, 32'hC000_0002, 32'h1C00_0400, 2'd2, 3, 2'b11, 32'hB000_0001, 32'h1C00_0300};
    tbl[4]  = '{0, 1, 2'b00, 32'h1111_1111, 32'h2222_2222, 32'h1C00_0F00, 2'd1, 2, 2'b11, 32'hC000_0001, 32'h1C00_0400};
    tbl[5]  = '{0, 0, 2'b11, 32'h3333_3333, 32'h4444_4444, 32'h1C00_0F00, 2'd2, 0, 2'b00, `INST_NOP, `PC_RESET};
    tbl[6]  = '{0, 1, 2'b11, 32'hD000_0001, 32'hD000_0002, 32'h1C00_0500, 2'd0, 2, 2'b11, 32'hD000_0001, 32'h1C00_0500};
    tbl[7]  = '{0, 1, 2'b11, 32'hE000_0001, 32'hE000_0002, 32'h1C00_0600, 2'd0, 4, 2'b11, 32'hD000_0001, 32'h1C00_0500};
    tbl[8]  = '{0, 1, 2'b01, 32'hF000_0001, 32'h0, 32'h1C00_0700, 2'd0, 5, 2'b11, 32'hD000_0001, 32'h1C00_0500};
    tbl[9]  = '{1, 1, 2'b11, 32'h5555_5555, 32'h6666_6666, 32'h1C00_0E00, 2'd1, 0, 2'b00, `INST_NOP, `PC_RESET};
    tbl[10] = '{0, 1, 2'b01, 32'h6000_0001, 32'h0, 32'h1C00_0800, 2'd0, 1, 2'b01, 32'h6000_0001, 32'h1C00_0800};
    tbl[11] = '{0, 0, 2'b00, 32'h0, 32'h0, 32'h0, 2'd2, 0, 2'b00, `INST_NOP, `PC_RESET};
    tbl[12] = '{0, 1, 2'b11, 32'h7000_0001, 32'h7000_0002, 32'h1C00_0900, 2'd0, 2, 2'b11, 32'h7000_0001, 32'h1C00_0900};

    do_reset();

    // Directed vectors: compaction, dual pop+write, flush, over-pop.
    for (int i = 0; i < 13; i++) begin
      step(tbl[i].fl, tbl[i].v, tbl[i].m, tbl[i].i0, tbl[i].i1, tbl[i].pc, tbl[i].pop);
      check($sformatf("vec%0d_count", i), 64'(count), 64'(tbl[i].cnt));
      check($sformatf("vec%0d_valid", i), 64'(out_valid), 64'(tbl[i].vld));
      check($sformatf("vec%0d_inst0", i), 64'(out_inst0), 64'(tbl[i].hi));
      check($sformatf("vec%0d_pc0", i), 64'(out_pc0), 64'(tbl[i].hpc));
    end

    // Reset mid-operation, then fill to backpressure.
    do_reset();
    for (int i = 0; i < 6; i++)
      step(0, 1, 2'b11, 32'h8000_0000 + 32'(2*i), 32'h8000_0001 + 32'(2*i), 32'h1C00_1000 + 32'(8*i), 2'd0);
    check("fill6_count", 64'(count), 12);
    check("fill6_nf", 64'(nearly_full), 0);
    step(0, 1, 2'b11, 32'h8000_000C, 32'h8000_000D, 32'h1C00_1030, 2'd0);
    check("fill7_count", 64'(count), 14);
    check("fill7_nf", 64'(nearly_full), 1);
    check("fill7_ready", 64'(in_ready), 1);
    step(0, 1, 2'b11, 32'h8000_000E, 32'h8000_000F, 32'h1C00_1038, 2'd0);
    check("fill8_count", 64'(count), 16);
    check("fill8_ready", 64'(in_ready), 0);
    step(0, 1, 2'b11, 32'h9999_9999, 32'h9999_999A, 32'h1C00_1040, 2'd0);
    check("fill9_count", 64'(count), 16);
    check("fill9_head", 64'(out_inst0), 64'h8000_0000);
    for (int i = 0; i < 8; i++) step(0, 0, 2'b00, 0, 0, 0, 2'd2);
    check("drain_count", 64'(count), 0);

    // Steady dual write / dual pop across pointer wrap.
    step(0, 1, 2'b11, 32'hC0DE_0000, 32'hC0DE_0001, 32'h1C00_2000, 2'd0);
    for (int i = 0; i < 40; i++) begin
      step(0, 1, 2'b11, $urandom, $urandom, $urandom & 32'hFFFF_FFFC, 2'd2);
      check("wrap_count", 64'(count), 2);
    end
    step(0, 0, 2'b00, 0, 0, 0, 2'd2);
    chk_outputs();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
